// File: rtl/map_pkg.sv
// Shared map definitions: tile codes, frame marker and loader state encoding.
// Imported by the map loader and by the renderer's colour/allow decode.
package map_pkg;

  localparam logic [7:0]  HDR_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned NUM_TILES        = 12;

  localparam logic [3:0] TILE_VOID        = 4'd0;
  localparam logic [3:0] TILE_WALL        = 4'd1;
  localparam logic [3:0] TILE_GRASS       = 4'd2;
  localparam logic [3:0] TILE_SAND        = 4'd3;
  localparam logic [3:0] TILE_SLOPE_FIRST = 4'd4;
  localparam logic [3:0] TILE_SLOPE_LAST  = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_HDR = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_WR_HI    = 3'd3,
    ST_WR_LO    = 3'd4,
    ST_CHECK    = 3'd5
  } load_state_e;

endpackage

// File: rtl/map_loader_if.sv
// Byte stream from the host link into the map loader (valid/ready handshake).
interface map_loader_if;

  logic       byte_valid_in;
  logic [7:0] byte_in;
  logic       byte_ready_out;

  modport master (output byte_valid_in, output byte_in, input byte_ready_out);
  modport slave  (input byte_valid_in, input byte_in, output byte_ready_out);

endinterface

// File: rtl/tile_nibble_check.sv
// Validates one tile nibble; codes outside the legal range are replaced by TILE_VOID.
module tile_nibble_check
  import map_pkg::*;
(
  input  logic [3:0] tile,
  output logic [3:0] code,
  output logic       legal
);

  assign legal = 32'(tile) < NUM_TILES;
  assign code  = legal ? tile : TILE_VOID;

endmodule

// File: rtl/map_loader.sv
// Writer side of the tile map RAM: unpacks a framed byte stream into two tiles per
// byte, checks header and XOR checksum, and reports done/error to game control.
module map_loader
  import map_pkg::*;
#(
  parameter int unsigned WIDTH    = 160,
  parameter int unsigned HEIGHT   = 90,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEFAULT,
  localparam int unsigned NUM_CELLS = WIDTH * HEIGHT,
  localparam int unsigned AW        = $clog2(NUM_CELLS)
) (
  input  logic            pixel_clk_in,
  input  logic            rst_in,
  input  logic            start_in,
  map_loader_if.slave     stream,
  output logic            wea_out,
  output logic [AW-1:0]   addr_out,
  output logic [3:0]      data_out,
  output logic            busy_out,
  output logic            done_out,
  output logic            error_out
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_CELLS - 1);

  load_state_e   state, state_nx;
  logic [AW-1:0] k_q, k_d;
  logic [7:0]    csum_q, csum_d;
  logic [3:0]    lo_q, lo_d;

  logic          wea_d, busy_d, done_d, error_d;
  logic [AW-1:0] addr_d;
  logic [3:0]    data_d;

  logic          ready, accept, last_pair;
  logic [3:0]    hi_code, lo_code;
  logic          hi_legal, lo_legal;

  assign last_pair = (k_q + AW'(1)) == LAST_ADDR;

  // The final low-nibble cycle holds the stream so the checksum byte is taken in CHECK.
  always_comb begin
    ready = 1'b0;
    case (state)
      ST_WAIT_HDR, ST_PAYLOAD, ST_CHECK: ready = 1'b1;
      ST_WR_LO:                          ready = ~last_pair;
      default:                           ready = 1'b0;
    endcase
  end

  assign stream.byte_ready_out = ready;
  assign accept                = stream.byte_valid_in & ready;

  tile_nibble_check u_hi_check (
    .tile  (stream.byte_in[7:4]),
    .code  (hi_code),
    .legal (hi_legal)
  );

  tile_nibble_check u_lo_check (
    .tile  (lo_q),
    .code  (lo_code),
    .legal (lo_legal)
  );

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state; start_in restarts from any state.
  always_comb begin
    state_nx = state;
    if (start_in) begin
      state_nx = ST_WAIT_HDR;
    end else begin
      case (state)
        ST_IDLE:     state_nx = ST_IDLE;
        ST_WAIT_HDR: if (accept && stream.byte_in == HDR_BYTE) state_nx = ST_PAYLOAD;
        ST_PAYLOAD:  if (accept) state_nx = ST_WR_HI;
        ST_WR_HI:    state_nx = ST_WR_LO;
        ST_WR_LO: begin
          if (last_pair)   state_nx = ST_CHECK;
          else if (accept) state_nx = ST_WR_HI;
          else             state_nx = ST_PAYLOAD;
        end
        ST_CHECK:    if (accept) state_nx = ST_IDLE;
        default:     state_nx = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    wea_d   = 1'b0;
    addr_d  = addr_out;
    data_d  = data_out;
    done_d  = 1'b0;
    error_d = error_out;
    k_d     = k_q;
    csum_d  = csum_q;
    lo_d    = lo_q;
    busy_d  = state_nx != ST_IDLE;
    if (start_in) begin
      error_d = 1'b0;
      k_d     = '0;
      csum_d  = '0;
    end else begin
      case (state)
        ST_PAYLOAD: begin
          if (accept) begin
            wea_d   = 1'b1;
            addr_d  = k_q;
            data_d  = hi_code;
            error_d = error_out | ~hi_legal;
            csum_d  = csum_q ^ stream.byte_in;
            lo_d    = stream.byte_in[3:0];
          end
        end
        ST_WR_HI: begin
          wea_d   = 1'b1;
          addr_d  = k_q + AW'(1);
          data_d  = lo_code;
          error_d = error_out | ~lo_legal;
        end
        ST_WR_LO: begin
          if (!last_pair) begin
            k_d = k_q + AW'(2);
            if (accept) begin
              wea_d   = 1'b1;
              addr_d  = k_q + AW'(2);
              data_d  = hi_code;
              error_d = error_out | ~hi_legal;
              csum_d  = csum_q ^ stream.byte_in;
              lo_d    = stream.byte_in[3:0];
            end
          end
        end
        ST_CHECK: begin
          if (accept) begin
            done_d = 1'b1;
            if (stream.byte_in != csum_q) error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      wea_out   <= 1'b0;
      addr_out  <= '0;
      data_out  <= '0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      error_out <= 1'b0;
      k_q       <= '0;
      csum_q    <= '0;
      lo_q      <= '0;
    end else begin
      wea_out   <= wea_d;
      addr_out  <= addr_d;
      data_out  <= data_d;
      busy_out  <= busy_d;
      done_out  <= done_d;
      error_out <= error_d;
      k_q       <= k_d;
      csum_q    <= csum_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_map_loader.sv
// Directed bench for map_loader on a 4x2 map.
module tb_map_loader;
  import map_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned AW = 3;

  typedef logic [7:0] seq_t [8];
  typedef logic [3:0] tiles_t [8];

  logic          pixel_clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic          wea_out;
  logic [AW-1:0] addr_out;
  logic [3:0]    data_out;
  logic          busy_out, done_out, error_out;

  map_loader_if stream ();

  map_loader #(.WIDTH(W), .HEIGHT(H), .HDR_BYTE(8'hA5)) dut (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .start_in     (start_in),
    .stream       (stream),
    .wea_out      (wea_out),
    .addr_out     (addr_out),
    .data_out     (data_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .error_out    (error_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int done_cnt     = 0;
  logic [AW-1:0] wr_addr [$];
  logic [3:0]    wr_data [$];
  int            wr_cyc  [$];
  int            acc_cyc [$];

  always @(posedge pixel_clk_in) cyc <= cyc + 1;

  // Log RAM writes, done pulses and accepted bytes away from the active edge.
  always @(negedge pixel_clk_in) begin
    if (wea_out === 1'b1) begin
      wr_addr.push_back(addr_out);
      wr_data.push_back(data_out);
      wr_cyc.push_back(cyc);
    end
    if (done_out === 1'b1) done_cnt++;
    if (stream.byte_valid_in === 1'b1 && stream.byte_ready_out === 1'b1) acc_cyc.push_back(cyc);
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    acc_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    @(posedge pixel_clk_in); #1;
    start_in = 1'b0;
  endtask

  // Valid stays high across the whole sequence; each byte waits for ready.
  task automatic send_seq(input seq_t seq, input int n);
    int waited;
    for (int i = 0; i < n; i++) begin
      stream.byte_in       = seq[i];
      stream.byte_valid_in = 1'b1;
      waited = 0;
      @(negedge pixel_clk_in);
      while (stream.byte_ready_out !== 1'b1 && waited < 20) begin
        @(negedge pixel_clk_in);
        waited++;
      end
      if (waited >= 20) begin
        tests_run++; tests_failed++;
        $display("FAIL send_timeout byte %0d: ready stayed low for 20 cycles", i);
      end
      @(posedge pixel_clk_in); #1;
    end
    stream.byte_valid_in = 1'b0;
  endtask

  task automatic check_writes(input string name, input tiles_t exp, input int n);
    tests_run++;
    if (wr_addr.size() != n) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d writes, expected %0d", name, wr_addr.size(), n);
    end
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      tests_run++;
      if (wr_addr[i] !== AW'(i) || wr_data[i] !== exp[i]) begin
        tests_failed++;
        $display("FAIL %s_write%0d: got addr %0d data %0d, expected addr %0d data %0d",
                 name, i, wr_addr[i], wr_data[i], i, exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; start_in = 1'b0;
    stream.byte_valid_in = 1'b0; stream.byte_in = 8'h00;
    repeat (3) @(posedge pixel_clk_in);
    @(negedge pixel_clk_in);
    tests_run++;
    if ({wea_out, addr_out, data_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_wr: got wea %b addr %0d data %0d, expected 0 0 0", wea_out, addr_out, data_out);
    end
    tests_run++;
    if ({stream.byte_ready_out, busy_out, done_out, error_out} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got rdy/busy/done/err %b, expected 0000",
               {stream.byte_ready_out, busy_out, done_out, error_out});
    end
    @(posedge pixel_clk_in); #1;
    rst_in = 1'b0;
  endtask

  task automatic test_nominal();
    clear_log();
    pulse_start();
    send_seq('{8'hA5, 8'h12, 8'h34, 8'h56, 8'h70, 8'h00, 8'h00, 8'h00}, 6);
    @(negedge pixel_clk_in);
    tests_run++;
    if ({done_out, busy_out, error_out} !== 3'b100) begin
      tests_failed++;
      $display("FAIL nominal_end: got done/busy/err %b, expected 100", {done_out, busy_out, error_out});
    end
    repeat (3) @(negedge pixel_clk_in);
    tests_run++;
    if (done_cnt != 1) begin
      tests_failed++;
      $display("FAIL nominal_done_cnt: got %0d pulses, expected 1", done_cnt);
    end
    check_writes("nominal", '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0}, 8);
    tests_run++;
    if (wr_cyc.size() < 2 || acc_cyc.size() < 2 ||
        wr_cyc[0] - acc_cyc[1] != 1 || wr_cyc[1] - acc_cyc[1] != 2) begin
      tests_failed++;
      $display("FAIL nominal_latency: got hi/lo write %0d/%0d cycles after accept, expected 1/2",
               (wr_cyc.size() > 0 && acc_cyc.size() > 1) ? wr_cyc[0] - acc_cyc[1] : -1,
               (wr_cyc.size() > 1 && acc_cyc.size() > 1) ? wr_cyc[1] - acc_cyc[1] : -1);
    end
    @(posedge pixel_clk_in); #1;
  endtask

  task automatic test_garbage();
    clear_log();
    pulse_start();
    send_seq('{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    repeat (2) @(negedge pixel_clk_in);
    tests_run++;
    if (wr_addr.size() != 0 || busy_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL garbage_ignored: got %0d writes busy %b, expected 0 writes busy 1", wr_addr.size(), busy_out);
    end
    @(posedge pixel_clk_in); #1;
    send_seq('{8'hA5, 8'h89, 8'hAB, 8'h01, 8'h24, 8'h07, 8'h00, 8'h00}, 6);
    @(negedge pixel_clk_in);
    tests_run++;
    if ({done_out, error_out} !== 2'b10) begin
      tests_failed++;
      $display("FAIL garbage_end: got done/err %b, expected 10", {done_out, error_out});
    end
    check_writes("garbage", '{4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd1, 4'd2, 4'd4}, 8);
    @(posedge pixel_clk_in); #1;
  endtask

  task automatic test_bad_checksum();
    clear_log();
    pulse_start();
    send_seq('{8'hA5, 8'h12, 8'h34, 8'h56, 8'h70, 8'h01, 8'h00, 8'h00}, 6);
    @(negedge pixel_clk_in);
    tests_run++;
    if ({done_out, error_out} !== 2'b11) begin
      tests_failed++;
      $display("FAIL badsum_end: got done/err %b, expected 11", {done_out, error_out});
    end
    check_writes("badsum", '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0}, 8);
    repeat (4) @(negedge pixel_clk_in);
    tests_run++;
    if (error_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL badsum_sticky: got error %b, expected 1", error_out);
    end
    @(posedge pixel_clk_in); #1;
    pulse_start();
    @(negedge pixel_clk_in);
    tests_run++;
    if ({error_out, busy_out} !== 2'b01) begin
      tests_failed++;
      $display("FAIL badsum_clear: got err/busy %b, expected 01", {error_out, busy_out});
    end
    @(posedge pixel_clk_in); #1;
  endtask

  task automatic test_illegal_tile();
    clear_log();
    pulse_start();
    send_seq('{8'hA5, 8'hC3, 8'h12, 8'h34, 8'h56, 8'hB3, 8'h00, 8'h00}, 6);
    @(negedge pixel_clk_in);
    tests_run++;
    if ({done_out, error_out} !== 2'b11) begin
      tests_failed++;
      $display("FAIL illegal_end: got done/err %b, expected 11", {done_out, error_out});
    end
    check_writes("illegal", '{4'd0, 4'd3, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6}, 8);
    @(posedge pixel_clk_in); #1;
  endtask

  task automatic test_back_to_back();
    clear_log();
    pulse_start();
    send_seq('{8'hA5, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    @(negedge pixel_clk_in);
    tests_run++;
    if (stream.byte_ready_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_ready_low: got ready %b in high-nibble cycle, expected 0", stream.byte_ready_out);
    end
    @(negedge pixel_clk_in);
    @(posedge pixel_clk_in); #1;
    pulse_start();
    stream.byte_in = 8'h33; stream.byte_valid_in = 1'b1;
    repeat (4) @(posedge pixel_clk_in);
    #1 stream.byte_valid_in = 1'b0;
    @(negedge pixel_clk_in);
    check_writes("abort", '{4'd1, 4'd1, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0}, 4);
    tests_run++;
    if (acc_cyc.size() < 3 || acc_cyc[1] - acc_cyc[0] != 1 || acc_cyc[2] - acc_cyc[1] != 2) begin
      tests_failed++;
      $display("FAIL b2b_rate: got payload accept spacing %0d, expected 2",
               acc_cyc.size() >= 3 ? acc_cyc[2] - acc_cyc[1] : -1);
    end
    tests_run++;
    if (done_cnt != 0 || busy_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_state: got done_cnt %0d busy %b, expected 0 and 1", done_cnt, busy_out);
    end
    @(posedge pixel_clk_in); #1;
    clear_log();
    send_seq('{8'hA5, 8'h76, 8'h54, 8'h32, 8'h19, 8'h09, 8'h00, 8'h00}, 6);
    repeat (3) @(negedge pixel_clk_in);
    check_writes("restart", '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd9}, 8);
    tests_run++;
    if (done_cnt != 1 || error_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_end: got done_cnt %0d err %b, expected 1 and 0", done_cnt, error_out);
    end
    @(posedge pixel_clk_in); #1;
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_seq('{8'hA5, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    rst_in = 1'b1;
    @(posedge pixel_clk_in); #1;
    rst_in = 1'b0;
    @(negedge pixel_clk_in);
    tests_run++;
    if ({wea_out, busy_out, stream.byte_ready_out} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rstmid_state: got wea/busy/ready %b, expected 000",
               {wea_out, busy_out, stream.byte_ready_out});
    end
    @(posedge pixel_clk_in); #1;
    clear_log();
    stream.byte_in = 8'hA5; stream.byte_valid_in = 1'b1;
    repeat (5) @(posedge pixel_clk_in);
    #1 stream.byte_valid_in = 1'b0;
    @(negedge pixel_clk_in);
    tests_run++;
    if (wr_addr.size() != 0 || acc_cyc.size() != 0 || busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_ignore: got %0d writes %0d accepts busy %b, expected 0 0 0",
               wr_addr.size(), acc_cyc.size(), busy_out);
    end
    @(posedge pixel_clk_in); #1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_garbage();
    test_bad_checksum();
    test_illegal_tile();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
